// File: rtl/bram_rd_port_buf.sv
// Buffered BRAM read port: credit-gated request issue, valid/tag return pipe, FWFT output FIFO.
// Latency RD_LATENCY+1 cycles accept-to-output; addr_ready drops only when every FIFO slot is already spoken for.

module bram_rd_port_buf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          full;

  assign pop    = rd_vld & rd_rdy;
  assign rd_vld = (count != '0);
  assign full   = (count == DEPTH_C);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({wr_vld, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  // Upstream credit gating should make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(wr_vld && full));
endmodule

module bram_rd_port_buf #(
  parameter int W_DATA     = 8,
  parameter int W_ADDR     = 12,
  parameter int W_TAG      = 1,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          addr_valid,
  output logic                          addr_ready,
  input  logic [W_ADDR-1:0]             addr_data,
  input  logic [W_TAG-1:0]              addr_tag,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [W_DATA-1:0]             data,
  output logic [W_TAG-1:0]              data_tag,
  output logic                          en,
  output logic [W_ADDR-1:0]             addr,
  input  logic [W_DATA-1:0]             rdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int W_LVL = $clog2(FIFO_DEPTH) + 1;
  localparam logic [W_LVL-1:0] DEPTH_L = W_LVL'(FIFO_DEPTH);

  typedef struct packed {
    logic [W_TAG-1:0]  tag;
    logic [W_DATA-1:0] dat;
  } rd_word_t;

  logic [W_LVL-1:0]      credits;
  logic                  pop;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [W_TAG-1:0]      pipe_tag [RD_LATENCY];
  rd_word_t              wr_word;
  rd_word_t              head;

  // Registered-only ready: a pop frees its credit for the following cycle.
  assign addr_ready = (credits < DEPTH_L);
  assign en         = addr_valid & addr_ready;
  assign addr       = addr_data;
  assign pop        = data_valid & data_ready;
  assign busy       = (credits != '0);
  assign level      = credits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= '0;
    end else begin
      case ({en, pop})
        2'b10:   credits <= credits + W_LVL'(1);
        2'b01:   credits <= credits - W_LVL'(1);
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= en;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= addr_tag;
    for (int i = 1; i < RD_LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  assign wr_word = '{tag: pipe_tag[RD_LATENCY-1], dat: rdata};

  bram_rd_port_buf_fifo #(
    .W     ($bits(rd_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (pipe_vld[RD_LATENCY-1]),
    .wr_dat (wr_word),
    .rd_rdy (data_ready),
    .rd_vld (data_valid),
    .rd_dat (head)
  );

  assign data     = head.dat;
  assign data_tag = head.tag;
endmodule
